// File: rtl/data_mem_resp.sv
// Load/store responder: fixed-latency access to a word array, sign/zero-extended reads.
// MISALIGN_CHECK_EN: flag misaligned accesses instead of aligning them down.
module data_mem_resp #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_n;

    logic [3:0]            cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  fire;
    logic                  is_b;
    logic                  is_h;
    logic                  is_w;
    logic [1:0]            off;
    logic [ADDR_WIDTH-3:0] idx;
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic [31:0]           rword;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [31:0]           ld;
    logic                  err_n;
    logic                  wr_en;
    logic [31:0]           rdata_n;

    assign accept = (state == IDLE) && req_valid;
    assign fire   = (state == WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req_valid)    state_n = WAIT;
            WAIT:    if (cnt == 4'd0)  state_n = RESP;
            RESP:    if (resp_ready)   state_n = IDLE;
            default:                   state_n = IDLE;
        endcase
    end

    // Gate on rst so the port reads 0 while the async reset is held.
    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            cnt     <= 4'(LATENCY - 1);
            we_q    <= req_we;
            addr_q  <= req_addr;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        is_b  = (size_q == 2'b00);
        is_h  = (size_q == 2'b01);
        is_w  = size_q[1];
        idx   = addr_q[ADDR_WIDTH-1:2];
        off   = addr_q[1:0];
        err_n = 1'b0;
`ifdef MISALIGN_CHECK_EN
        err_n = (is_h && addr_q[0]) || (is_w && (addr_q[1:0] != 2'b00));
`else
        if (is_h) off[0] = 1'b0;
        if (is_w) off    = 2'b00;
`endif
        be    = 4'b1111;
        wlane = wdata_q;
        unique case (1'b1)
            is_b: begin
                be    = 4'b0001 << off;
                wlane = {4{wdata_q[7:0]}};
            end
            is_h: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    always_comb begin
        rword  = mem[idx];
        byte_v = rword[{off, 3'b000} +: 8];
        half_v = rword[{off[1], 4'b0000} +: 16];
        ld     = rword;
        unique case (1'b1)
            is_b:    ld = {{24{byte_v[7] & ~uns_q}}, byte_v};
            is_h:    ld = {{16{half_v[15] & ~uns_q}}, half_v};
            default: ld = rword;
        endcase
        rdata_n = (we_q || err_n) ? 32'd0 : ld;
        wr_en   = fire && we_q && !err_n;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (fire) begin
            rdata_q <= rdata_n;
            err_q   <= err_n;
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized bench for data_mem_resp against a byte-addressed memory model.
// Honours MISALIGN_CHECK_EN the same way the design does.
module tb_data_mem_resp;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] mb [0:(1<<AW)-1];

    always #5 clk = ~clk;

    data_mem_resp #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic we, input logic [AW-1:0] a,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] wd,
                         output logic [31:0] ed, output logic ee);
        int nb;
        int base;
        logic [31:0] v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a) - (int'(a) % nb);
        ed   = 32'd0;
        ee   = 1'b0;
`ifdef MISALIGN_CHECK_EN
        if ((int'(a) % nb) != 0) begin
            ee = 1'b1;
            return;
        end
`endif
        if (we) begin
            for (int i = 0; i < nb; i++) mb[base+i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base+i];
            if (!uns && nb < 4 && v[8*nb-1])
                v = v | (32'hFFFF_FFFF << (8*nb));
            ed = v;
        end
    endtask

    task automatic txn(input logic we, input logic [AW-1:0] a,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er);
        logic [31:0] ed;
        logic        ee;
        int          n;
        model(we, a, sz, uns, wd, ed, ee);
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = uns;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_addr     = AW'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!resp_valid)
                chk("req_ready_wait", {31'd0, req_ready}, 32'd0);
        end while (!resp_valid && n < 40);
        chk("latency", n, LAT + 1);
        rd = resp_rdata;
        er = resp_err;
        chk("rdata", rd, ed);
        chk("err", {31'd0, er}, {31'd0, ee});
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("drop_valid", {31'd0, resp_valid}, 32'd0);
        chk("back_idle", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        for (int w = 0; w < (1 << (AW - 2)); w++)
            txn(1'b1, AW'(w * 4), 2'd2, 1'b0, $urandom, 0, rd, er);

        txn(1'b1, 10'h010, 2'd2, 1'b0, 32'hDEADBEEF, 0, rd, er);
        chk("tp_st_rdata", rd, 32'd0);
        txn(1'b0, 10'h010, 2'd2, 1'b0, 32'd0, 0, rd, er);
        chk("tp_word", rd, 32'hDEADBEEF);

        txn(1'b1, 10'h020, 2'd2, 1'b0, 32'h80FF7F01, 0, rd, er);
        txn(1'b0, 10'h023, 2'd0, 1'b0, 32'd0, 0, rd, er);
        chk("tp_sb", rd, 32'hFFFFFF80);
        txn(1'b0, 10'h023, 2'd0, 1'b1, 32'd0, 0, rd, er);
        chk("tp_ub", rd, 32'h00000080);
        txn(1'b0, 10'h020, 2'd1, 1'b0, 32'd0, 0, rd, er);
        chk("tp_sh0", rd, 32'h00007F01);
        txn(1'b0, 10'h022, 2'd1, 1'b0, 32'd0, 0, rd, er);
        chk("tp_sh2", rd, 32'hFFFF80FF);

        txn(1'b1, 10'h030, 2'd2, 1'b0, 32'h11223344, 0, rd, er);
        txn(1'b1, 10'h031, 2'd0, 1'b0, 32'h000000AA, 0, rd, er);
        txn(1'b0, 10'h030, 2'd2, 1'b0, 32'd0, 0, rd, er);
        chk("tp_lane", rd, 32'h1122AA44);

        txn(1'b0, 10'h030, 2'd2, 1'b0, 32'd0, 5, rd, er);
        chk("tp_bp", rd, 32'h1122AA44);

        txn(1'b1, 10'h040, 2'd2, 1'b0, 32'd0, 0, rd, er);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'h040;
        req_size  = 2'd2;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_novalid", {31'd0, resp_valid}, 32'd0);
        end
        txn(1'b0, 10'h040, 2'd2, 1'b0, 32'd0, 0, rd, er);
        chk("abort_load", rd, 32'd0);

        txn(1'b1, 10'h040, 2'd2, 1'b0, 32'hCAFEF00D, 0, rd, er);
        txn(1'b0, 10'h042, 2'd2, 1'b0, 32'd0, 0, rd, er);
`ifdef MISALIGN_CHECK_EN
        chk("mis_err", {31'd0, er}, 32'd1);
        chk("mis_rdata", rd, 32'd0);
`else
        chk("mis_err", {31'd0, er}, 32'd0);
        chk("mis_rdata", rd, 32'hCAFEF00D);
`endif

        for (int t = 0; t < 400; t++) begin
            txn(1'($urandom), AW'($urandom), 2'($urandom), 1'($urandom),
                $urandom, int'($urandom_range(0, 3)), rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
